// File: rtl/soc_apb_timer_ctrl.sv
// rtl/soc_apb_timer_ctrl.sv - sequencer for one timer counter channel
//
// Purpose:
//   Turns the channel configuration and the start/stop/clear command pulses
//   into the reset_count/enable_count strobes for the counter datapath.
//   Provides a prescaler, one-shot or auto-reload operation, and a registered
//   single-cycle match interrupt.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cfg_enable_i         channel enable level; low forces IDLE
//   cfg_oneshot_i        1: stop after the first match, 0: auto-reload
//   cfg_presc_en_i       1: tick every (cfg_presc_val_i+1) cycles, 0: every cycle
//   cfg_presc_val_i      prescaler terminal value
//   start_i, stop_i,
//   clear_i              single-cycle command pulses
//   target_reached_i     counter == compare flag from the datapath
//   reset_count_o        synchronous counter clear this cycle
//   enable_count_o       counter increment this cycle
//   irq_o                match interrupt, one-cycle registered pulse
//   busy_o               channel is in RUN

module soc_apb_timer_ctrl #(
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_enable_i,
  input  logic               cfg_oneshot_i,
  input  logic               cfg_presc_en_i,
  input  logic [PRESC_W-1:0] cfg_presc_val_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               clear_i,
  input  logic               target_reached_i,
  output logic               reset_count_o,
  output logic               enable_count_o,
  output logic               irq_o,
  output logic               busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic               tr_seen_q;
  logic               irq_q;

  logic in_run;
  logic start_ok;
  logic clear_ok;
  logic tick;
  logic reload;
  logic match;

  assign in_run   = (state_q == ST_RUN);

  // A start is ignored whenever a higher-priority command shares its cycle.
  assign start_ok = cfg_enable_i & start_i & ~clear_i & ~stop_i;
  assign clear_ok = cfg_enable_i & clear_i;

  assign tick     = in_run & (~cfg_presc_en_i | (presc_cnt_q == cfg_presc_val_i));
  assign reload   = in_run & ~cfg_oneshot_i & tick & target_reached_i;

  assign reset_count_o  = start_ok | clear_ok | reload;
  assign enable_count_o = tick & ~reset_count_o;

  // Only the first cycle of target_reached_i counts as a match, so a counter
  // parked at compare between prescaler ticks raises a single interrupt.
  assign match = in_run & target_reached_i & ~tr_seen_q;

  always_comb begin
    state_d = state_q;
    if (!cfg_enable_i) begin
      state_d = ST_IDLE;
    end else if (stop_i && in_run) begin
      state_d = ST_IDLE;
    end else if (start_ok) begin
      state_d = ST_RUN;
    end else if (in_run && match && cfg_oneshot_i && !clear_i) begin
      state_d = ST_DONE;
    end else if (state_q != ST_IDLE && state_q != ST_RUN && state_q != ST_DONE) begin
      state_d = ST_IDLE;
    end
  end

  // The prescaler only advances while the channel stays in RUN undisturbed;
  // every other path (tick wrap, clear, restart, leaving RUN) zeroes it.
  always_comb begin
    presc_cnt_d = '0;
    if (in_run && (state_d == ST_RUN) && !clear_i && !start_ok && !tick) begin
      presc_cnt_d = presc_cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      presc_cnt_q <= '0;
      tr_seen_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_cnt_q <= presc_cnt_d;
      tr_seen_q   <= target_reached_i & ~reset_count_o;
      irq_q       <= match;
    end
  end

  assign irq_o  = irq_q;
  assign busy_o = in_run;

endmodule

// File: tb/tb_soc_apb_timer_ctrl.sv
// tb/tb_soc_apb_timer_ctrl.sv - self-checking bench for soc_apb_timer_ctrl

module tb_soc_apb_timer_ctrl;

  localparam int S_IDLE = 10;
  localparam int S_RUN  = 11;
  localparam int S_DONE = 12;

  logic       clk;
  logic       rst_ni;
  logic       en;
  logic       oneshot;
  logic       presc_en;
  logic [7:0] presc_val;
  logic       start;
  logic       stop;
  logic       clear;
  logic       tr;
  logic       reset_count_o;
  logic       enable_count_o;
  logic       irq_o;
  logic       busy_o;

  int n_vec = 0;
  int n_err = 0;

  int m_state = S_IDLE;
  int m_presc = 0;
  bit m_seen  = 1'b0;
  bit m_irq   = 1'b0;

  int cnt = 0;
  int cmp = 0;
  int cyc = 0;
  int irq_total = 0;
  int evt_total = 0;
  int irq_q[$];
  int evt_q[$];
  bit obs_rc;
  bit obs_ec;

  soc_apb_timer_ctrl #(.PRESC_W(8)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .cfg_enable_i     (en),
    .cfg_oneshot_i    (oneshot),
    .cfg_presc_en_i   (presc_en),
    .cfg_presc_val_i  (presc_val),
    .start_i          (start),
    .stop_i           (stop),
    .clear_i          (clear),
    .target_reached_i (tr),
    .reset_count_o    (reset_count_o),
    .enable_count_o   (enable_count_o),
    .irq_o            (irq_o),
    .busy_o           (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: predict outputs from the channel rules, compare, then
  // advance the reference model and the counter datapath stand-in.
  task automatic step();
    bit acc, run, tick, reload, rc, ec, match;
    int nxt, nprs;
    tr = (cnt == cmp);
    #1;
    run    = (m_state == S_RUN);
    acc    = en && start && !clear && !stop;
    tick   = run && (!presc_en || m_presc == int'(presc_val));
    reload = run && !oneshot && tick && tr;
    rc     = acc || (clear && en) || reload;
    ec     = tick && !rc;
    match  = run && tr && !m_seen;
    obs_rc = reset_count_o;
    obs_ec = enable_count_o;
    n_vec += 4;
    if (reset_count_o !== rc) begin
      n_err++;
      $display("FAIL reset_count cyc=%0d got=%b exp=%b", cyc, reset_count_o, rc);
    end
    if (enable_count_o !== ec) begin
      n_err++;
      $display("FAIL enable_count cyc=%0d got=%b exp=%b", cyc, enable_count_o, ec);
    end
    if (irq_o !== m_irq) begin
      n_err++;
      $display("FAIL irq cyc=%0d got=%b exp=%b", cyc, irq_o, m_irq);
    end
    if (busy_o !== run) begin
      n_err++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, run);
    end
    if (irq_o === 1'b1) begin
      irq_q.push_back(cyc);
      evt_q.push_back(evt_total);
      irq_total++;
    end
    if (enable_count_o === 1'b1 || reset_count_o === 1'b1) evt_total++;

    nxt = m_state;
    if (!en)                                    nxt = S_IDLE;
    else if (stop && run)                       nxt = S_IDLE;
    else if (acc)                               nxt = S_RUN;
    else if (run && match && oneshot && !clear) nxt = S_DONE;
    nprs = (run && nxt == S_RUN && !clear && !acc && !tick) ? (m_presc + 1) % 256 : 0;

    @(posedge clk);
    m_state = nxt;
    m_presc = nprs;
    m_seen  = tr && !rc;
    m_irq   = match;
    if (obs_rc) cnt = 0;
    else if (obs_ec && cnt < cmp) cnt++;
    cyc++;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_presc = 0;
    m_seen  = 1'b0;
    m_irq   = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec += 4;
    if (reset_count_o !== 1'b0) begin n_err++; $display("FAIL reset_rc got=%b exp=0", reset_count_o); end
    if (enable_count_o !== 1'b0) begin n_err++; $display("FAIL reset_ec got=%b exp=0", enable_count_o); end
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    repeat (3) step();
  endtask

  task automatic test_oneshot();
    int s0;
    en = 1; oneshot = 1; presc_en = 0; presc_val = 0; cmp = 5;
    irq_q.delete();
    s0 = cyc;
    start = 1;
    repeat (14) step();
    n_vec += 4;
    if (irq_q.size() != 1) begin
      n_err++; $display("FAIL oneshot_irq_count got=%0d exp=1", irq_q.size());
    end else if (irq_q[0] - s0 != cmp + 2) begin
      n_err++; $display("FAIL oneshot_irq_time got=%0d exp=%0d", irq_q[0] - s0, cmp + 2);
    end
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL oneshot_busy got=%b exp=0", busy_o); end
    if (cnt != 5) begin n_err++; $display("FAIL oneshot_hold got=%0d exp=5", cnt); end
    if (m_state != S_DONE) begin n_err++; $display("FAIL oneshot_state got=%0d exp=%0d", m_state, S_DONE); end
  endtask

  task automatic test_autoreload_presc();
    en = 1; oneshot = 0; presc_en = 1; presc_val = 3; cmp = 2;
    irq_q.delete();
    evt_q.delete();
    start = 1;
    repeat (64) step();
    n_vec++;
    if (irq_q.size() < 5) begin
      n_err++; $display("FAIL reload_irq_count got=%0d exp>=5", irq_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (irq_q[i+1] - irq_q[i] != (cmp + 1) * (presc_val + 1)) begin
          n_err++;
          $display("FAIL reload_period[%0d] got=%0d exp=%0d", i, irq_q[i+1] - irq_q[i], (cmp + 1) * (presc_val + 1));
        end
      end
      n_vec++;
      if (evt_q[4] - evt_q[0] != 12) begin
        n_err++; $display("FAIL tick_rate got=%0d exp=12", evt_q[4] - evt_q[0]);
      end
    end
  endtask

  task automatic test_continuous();
    int base;
    en = 1; oneshot = 0; presc_en = 0; presc_val = 0; cmp = 0;
    start = 1;
    repeat (2) step();
    base = irq_total;
    repeat (8) step();
    n_vec++;
    if (irq_total - base != 8) begin
      n_err++; $display("FAIL cont_every_cycle got=%0d exp=8", irq_total - base);
    end
    presc_en = 1; presc_val = 2;
    repeat (6) step();
    base = irq_total;
    repeat (12) step();
    n_vec++;
    if (irq_total - base != 4) begin
      n_err++; $display("FAIL cont_every_third got=%0d exp=4", irq_total - base);
    end
  endtask

  task automatic test_stop_start();
    int guard;
    en = 1; oneshot = 0; presc_en = 0; presc_val = 0; cmp = 10;
    start = 1;
    step();
    guard = 0;
    while (cnt != 2 && guard < 20) begin
      step();
      guard++;
    end
    n_vec++;
    if (guard >= 20) begin n_err++; $display("FAIL stop_reach got=%0d exp=2", cnt); end
    stop = 1;
    step();
    n_vec++;
    if (obs_rc !== 1'b0) begin n_err++; $display("FAIL stop_no_reset got=%b exp=0", obs_rc); end
    repeat (4) step();
    n_vec += 2;
    if (cnt != 3) begin n_err++; $display("FAIL stop_hold got=%0d exp=3", cnt); end
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL stop_idle got=%b exp=0", busy_o); end
    start = 1;
    step();
    n_vec += 2;
    if (obs_rc !== 1'b1) begin n_err++; $display("FAIL restart_reset got=%b exp=1", obs_rc); end
    #1;
    if (busy_o !== 1'b1) begin n_err++; $display("FAIL restart_busy got=%b exp=1", busy_o); end
  endtask

  task automatic test_collision();
    en = 1; oneshot = 0; presc_en = 0; cmp = 10;
    start = 1;
    repeat (4) step();
    clear = 1; stop = 1; start = 1;
    step();
    n_vec += 3;
    if (obs_rc !== 1'b1) begin n_err++; $display("FAIL collide_reset got=%b exp=1", obs_rc); end
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL collide_idle got=%b exp=0", busy_o); end
    if (cnt != 0) begin n_err++; $display("FAIL collide_cnt got=%0d exp=0", cnt); end
    start = 1;
    repeat (4) step();
    en = 0; clear = 1; stop = 1; start = 1;
    step();
    n_vec += 2;
    if (obs_rc !== 1'b0) begin n_err++; $display("FAIL disabled_reset got=%b exp=0", obs_rc); end
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL disabled_idle got=%b exp=0", busy_o); end
    en = 1;
    repeat (2) step();
  endtask

  task automatic test_async_reset();
    int base;
    en = 1; oneshot = 0; presc_en = 0; presc_val = 0; cmp = 0;
    start = 1;
    repeat (3) step();
    #2;
    rst_ni = 1'b0;
    #1;
    n_vec += 2;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL async_irq got=%b exp=0", irq_o); end
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL async_busy got=%b exp=0", busy_o); end
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    base = irq_total;
    repeat (6) step();
    n_vec++;
    if (irq_total != base) begin n_err++; $display("FAIL post_reset_quiet got=%0d exp=0", irq_total - base); end
    start = 1;
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        oneshot   = ($urandom % 2) != 0;
        presc_en  = ($urandom % 2) != 0;
        presc_val = 8'($urandom_range(0, 4));
        cmp       = $urandom_range(0, 6);
      end
      en    = ($urandom % 16) != 0;
      start = ($urandom % 8) == 0;
      stop  = ($urandom % 24) == 0;
      clear = ($urandom % 30) == 0;
      step();
    end
  endtask

  initial begin
    en = 0; oneshot = 0; presc_en = 0; presc_val = 0;
    start = 0; stop = 0; clear = 0; tr = 0; rst_ni = 0;
    test_reset();
    test_oneshot();
    test_autoreload_presc();
    test_continuous();
    test_stop_start();
    test_collision();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
